// File: rtl/sort.sv
// Sequential 4-entry sorter: loads x0..x3 after reset, then runs a 6-step bubble network.
// Define SORT_DESCEND_EN to sort in descending order (s0 = largest).
module sort #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] s0,
    output logic [WIDTH-1:0] s1,
    output logic [WIDTH-1:0] s2,
    output logic [WIDTH-1:0] s3,
    output logic [2:0]       done
);

    localparam logic [2:0] STEP_LOAD = 3'd0;
    localparam logic [2:0] STEP_DONE = 3'd7;

    logic [WIDTH-1:0] r_w [4];
    logic [2:0]       r_step;

    logic [WIDTH-1:0] w_next [4];
    logic [2:0]       w_step_next;
    logic [1:0]       w_idx_lo;
    logic [1:0]       w_idx_hi;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_swap;

    // Which adjacent pair each step compares: (0,1) (1,2) (2,3) (0,1) (1,2) (0,1).
    always_comb begin
        w_idx_lo = 2'd0;
        case (r_step)
            3'd2, 3'd5: w_idx_lo = 2'd1;
            3'd3:       w_idx_lo = 2'd2;
            default:    w_idx_lo = 2'd0;
        endcase
        w_idx_hi = w_idx_lo + 2'd1;
    end

    assign w_a = r_w[w_idx_lo];
    assign w_b = r_w[w_idx_hi];

    // Strict compare keeps equal values in place.
`ifdef SORT_DESCEND_EN
    assign w_swap = (w_a < w_b);
`else
    assign w_swap = (w_a > w_b);
`endif

    always_comb begin
        w_next      = r_w;
        w_step_next = r_step;
        case (r_step)
            STEP_LOAD: begin
                w_next[0]   = x0;
                w_next[1]   = x1;
                w_next[2]   = x2;
                w_next[3]   = x3;
                w_step_next = 3'd1;
            end
            STEP_DONE: begin
                w_step_next = STEP_DONE;
            end
            default: begin
                if (w_swap) begin
                    w_next[w_idx_lo] = w_b;
                    w_next[w_idx_hi] = w_a;
                end
                w_step_next = r_step + 3'd1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w[0] <= '0;
            r_w[1] <= '0;
            r_w[2] <= '0;
            r_w[3] <= '0;
            r_step <= STEP_LOAD;
        end else begin
            r_w[0] <= w_next[0];
            r_w[1] <= w_next[1];
            r_w[2] <= w_next[2];
            r_w[3] <= w_next[3];
            r_step <= w_step_next;
        end
    end

    assign s0   = r_w[0];
    assign s1   = r_w[1];
    assign s2   = r_w[2];
    assign s3   = r_w[3];
    assign done = r_step;

endmodule

// File: tb/tb_sort.sv
// Self-checking bench for sort: directed cases plus random vectors checked against a queue-sort model.
// Honours SORT_DESCEND_EN to expect descending order.
module tb_sort;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] x0, x1, x2, x3;
    logic [W-1:0] s0, s1, s2, s3;
    logic [2:0]   done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] obs_s    [1:9][0:3];
    logic [2:0]   obs_done [1:9];

    sort #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .x0   (x0),
        .x1   (x1),
        .x2   (x2),
        .x3   (x3),
        .s0   (s0),
        .s1   (s1),
        .s2   (s2),
        .s3   (s3),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: the final result is just the four operands in sorted order.
    task automatic model(input int a, input int b, input int c, input int d, output int e[4]);
        int q[$];
        q = {a, b, c, d};
`ifdef SORT_DESCEND_EN
        q.rsort();
`else
        q.sort();
`endif
        for (int i = 0; i < 4; i++) e[i] = q[i];
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_s0"}, 32'(s0), 0);
        check({tag, "_s1"}, 32'(s1), 0);
        check({tag, "_s2"}, 32'(s2), 0);
        check({tag, "_s3"}, 32'(s3), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    // Reset with operands applied, then record 9 edges and check load, done count, result, hold.
    task automatic run_sort(input string tag, input int a, input int b, input int c, input int d,
                            input bit scramble);
        int e[4];
        @(negedge clk);
        x0 = W'(a); x1 = W'(b); x2 = W'(c); x3 = W'(d);
        rst = 1'b1;
        #1;
        check_zero({tag, "_rst_async"});
        @(posedge clk);
        #1;
        check_zero({tag, "_rst_held"});
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            obs_s[k][0] = s0; obs_s[k][1] = s1; obs_s[k][2] = s2; obs_s[k][3] = s3;
            obs_done[k] = done;
            check($sformatf("%s_done_e%0d", tag, k), 32'(done), (k < 7) ? k : 7);
            if (scramble) begin
                x0 = W'($urandom); x1 = W'($urandom); x2 = W'($urandom); x3 = W'($urandom);
            end
        end
        check({tag, "_load0"}, 32'(obs_s[1][0]), a);
        check({tag, "_load3"}, 32'(obs_s[1][3]), d);
        model(a, b, c, d, e);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_res%0d", tag, i), 32'(obs_s[7][i]), e[i]);
            check($sformatf("%s_hold%0d", tag, i), 32'(obs_s[9][i]), e[i]);
        end
    endtask

    int tab [1:6][0:4];

    initial begin
        int e[4];
        int a, b, c, d;
        rst = 1'b1;
        x0 = '0; x1 = '0; x2 = '0; x3 = '0;
        #12;
        check_zero("por");

        run_sort("sorted", 1, 2, 4, 8, 1'b0);

`ifdef SORT_DESCEND_EN
        run_sort("rev", 1, 2, 4, 8, 1'b0);
        tab = '{'{2, 1, 4, 8, 2}, '{2, 4, 1, 8, 3}, '{2, 4, 8, 1, 4},
                '{4, 2, 8, 1, 5}, '{4, 8, 2, 1, 6}, '{8, 4, 2, 1, 7}};
`else
        run_sort("rev", 8, 4, 2, 1, 1'b0);
        tab = '{'{4, 8, 2, 1, 2}, '{4, 2, 8, 1, 3}, '{4, 2, 1, 8, 4},
                '{2, 4, 1, 8, 5}, '{2, 1, 4, 8, 6}, '{1, 2, 4, 8, 7}};
`endif
        for (int j = 1; j <= 6; j++) begin
            for (int i = 0; i < 4; i++)
                check($sformatf("rev_step%0d_s%0d", j, i), 32'(obs_s[j + 1][i]), tab[j][i]);
            check($sformatf("rev_step%0d_done", j), 32'(obs_done[j + 1]), tab[j][4]);
        end

        run_sort("dup", 5, 5, 0, 15, 1'b0);

        // Abort between edges at step 3, then restart with new operands.
        @(negedge clk);
        x0 = 4'd8; x1 = 4'd4; x2 = 4'd2; x3 = 4'd1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) @(posedge clk);
        #2;
        check("mid_pre_done", 32'(done), 3);
        rst = 1'b1;
        #1;
        check_zero("mid_abort");
        run_sort("mid_restart", 3, 9, 1, 7, 1'b0);

        run_sort("scramble", 6, 3, 12, 0, 1'b1);
        run_sort("rereset", 11, 2, 9, 4, 1'b0);

        for (int r = 0; r < 15; r++) begin
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            c = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 15));
            run_sort($sformatf("rnd%0d", r), a, b, c, d, r[0]);
        end

        model(0, 0, 0, 0, e);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
